// File: rtl/voice_allocator.sv
// ----------------------------------------------------------------------------
// voice_allocator
//   Polyphonic voice scheduler. Note-on/note-off events are accepted one at a
//   time (IDLE -> SEARCH -> COMMIT). A note-on is placed on a voice chosen by
//   three rules, in order:
//     1. retrigger an active voice that already holds the same note;
//     2. otherwise use a free voice;
//     3. otherwise steal the oldest voice.
//   A note-off releases every active voice that holds the note.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   evt_valid_in/ready    event handshake (ready only in IDLE)
//   evt_on_in             1 = note-on, 0 = note-off
//   evt_note_in           note number
//   evt_incr_in           phase increment for a note-on
//   voice_active_out      gate per voice
//   voice_note_out        note per voice, voice i at [i*NOTE_W +: NOTE_W]
//   voice_incr_out        phase increment per voice, voice i at [i*INCR_W +: INCR_W]
//   voice_rst_out         1-cycle phase-reset pulse per voice
//   alloc_valid_out       1-cycle pulse when a note-on is committed
//   alloc_voice_out       voice used by the last committed note-on (held)
//   steal_out             with alloc_valid_out: a sounding voice was stolen
// ----------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_W     = 7,
    parameter int INCR_W     = 32,
    parameter int AGE_W      = 8
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             evt_valid_in,
    output logic                             evt_ready_out,
    input  logic                             evt_on_in,
    input  logic [NOTE_W-1:0]                evt_note_in,
    input  logic [INCR_W-1:0]                evt_incr_in,
    output logic [NUM_VOICES-1:0]            voice_active_out,
    output logic [NUM_VOICES*NOTE_W-1:0]     voice_note_out,
    output logic [NUM_VOICES*INCR_W-1:0]     voice_incr_out,
    output logic [NUM_VOICES-1:0]            voice_rst_out,
    output logic                             alloc_valid_out,
    output logic [$clog2(NUM_VOICES)-1:0]    alloc_voice_out,
    output logic                             steal_out
);

    localparam int VW = $clog2(NUM_VOICES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]                          r_state;
    logic                                r_on;
    logic [NOTE_W-1:0]                   r_note;
    logic [INCR_W-1:0]                   r_incr;

    logic [NUM_VOICES-1:0]               r_active;
    logic [NUM_VOICES-1:0][NOTE_W-1:0]   r_vnote;
    logic [NUM_VOICES-1:0][INCR_W-1:0]   r_vincr;
    logic [NUM_VOICES-1:0][AGE_W-1:0]    r_age;

    logic [NUM_VOICES-1:0]               r_vrst;
    logic                                r_alloc_valid;
    logic [VW-1:0]                       r_alloc_voice;
    logic                                r_steal;

    // Victim search (evaluated during SEARCH, applied on the edge leaving it)
    logic [NUM_VOICES-1:0]               w_match;
    logic                                w_retrig_hit;
    logic [VW-1:0]                       w_retrig_idx;
    logic                                w_free_hit;
    logic [VW-1:0]                       w_free_idx;
    logic [VW-1:0]                       w_old_idx;
    logic [AGE_W-1:0]                    w_old_age;
    logic [VW-1:0]                       w_victim;
    logic                                w_steal;

    always_comb begin
        w_match      = '0;
        w_retrig_hit = 1'b0;
        w_retrig_idx = '0;
        w_free_hit   = 1'b0;
        w_free_idx   = '0;
        // Walk downward so the lowest matching index is the one left standing.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            w_match[i] = r_active[i] && (r_vnote[i] == r_note);
            if (w_match[i]) begin
                w_retrig_hit = 1'b1;
                w_retrig_idx = VW'(i);
            end
            if (!r_active[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = VW'(i);
            end
        end
        // Oldest voice; strict '>' keeps the lowest index on ties. Only used
        // when every voice is active, so activity is not consulted here.
        w_old_idx = '0;
        w_old_age = r_age[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (r_age[i] > w_old_age) begin
                w_old_age = r_age[i];
                w_old_idx = VW'(i);
            end
        end
        w_steal  = 1'b0;
        if (w_retrig_hit) begin
            w_victim = w_retrig_idx;
        end else if (w_free_hit) begin
            w_victim = w_free_idx;
        end else begin
            w_victim = w_old_idx;
            w_steal  = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            r_on          <= 1'b0;
            r_note        <= '0;
            r_incr        <= '0;
            r_active      <= '0;
            r_vnote       <= '0;
            r_vincr       <= '0;
            r_age         <= '0;
            r_vrst        <= '0;
            r_alloc_valid <= 1'b0;
            r_alloc_voice <= '0;
            r_steal       <= 1'b0;
        end else begin
            // Pulses are set only on the SEARCH->COMMIT edge, so they are
            // high for exactly the COMMIT cycle.
            r_vrst        <= '0;
            r_alloc_valid <= 1'b0;
            r_steal       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (evt_valid_in) begin
                        r_on    <= evt_on_in;
                        r_note  <= evt_note_in;
                        r_incr  <= evt_incr_in;
                        r_state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    r_state <= S_COMMIT;
                    if (r_on) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (i == int'(w_victim)) begin
                                r_active[i] <= 1'b1;
                                r_vnote[i]  <= r_note;
                                r_vincr[i]  <= r_incr;
                                r_age[i]    <= '0;
                                r_vrst[i]   <= 1'b1;
                            end else if (r_active[i] && (r_age[i] != {AGE_W{1'b1}})) begin
                                r_age[i] <= r_age[i] + 1'b1;
                            end
                        end
                        r_alloc_valid <= 1'b1;
                        r_alloc_voice <= w_victim;
                        r_steal       <= w_steal;
                    end else begin
                        // Release matches; note/incr stay so the oscillator
                        // settings are still visible after the gate drops.
                        r_active <= r_active & ~w_match;
                    end
                end
                S_COMMIT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Not ready while reset is held, even though the state is already IDLE.
    assign evt_ready_out    = (r_state == S_IDLE) && !rst_in;
    assign voice_active_out = r_active;
    assign voice_note_out   = r_vnote;
    assign voice_incr_out   = r_vincr;
    assign voice_rst_out    = r_vrst;
    assign alloc_valid_out  = r_alloc_valid;
    assign alloc_voice_out  = r_alloc_voice;
    assign steal_out        = r_steal;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    localparam int NV = 8;
    localparam int NW = 7;
    localparam int IW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              evt_valid;
    logic              evt_ready;
    logic              evt_on;
    logic [NW-1:0]     evt_note;
    logic [IW-1:0]     evt_incr;
    logic [NV-1:0]     v_active;
    logic [NV*NW-1:0]  v_note;
    logic [NV*IW-1:0]  v_incr;
    logic [NV-1:0]     v_rst;
    logic              alloc_valid;
    logic [2:0]        alloc_voice;
    logic              steal;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .INCR_W(IW), .AGE_W(8)) dut (
        .clk_in(clk), .rst_in(rst),
        .evt_valid_in(evt_valid), .evt_ready_out(evt_ready),
        .evt_on_in(evt_on), .evt_note_in(evt_note), .evt_incr_in(evt_incr),
        .voice_active_out(v_active), .voice_note_out(v_note),
        .voice_incr_out(v_incr), .voice_rst_out(v_rst),
        .alloc_valid_out(alloc_valid), .alloc_voice_out(alloc_voice),
        .steal_out(steal)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: plain arrays describing each voice.
    bit          m_act  [NV];
    int          m_note [NV];
    logic [31:0] m_incr [NV];
    int          m_age  [NV];
    int          m_last;
    bit          m_av;
    bit          m_steal;
    logic [NV-1:0] m_vrst;

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 0; m_note[i] = 0; m_incr[i] = '0; m_age[i] = 0;
        end
        m_last = 0; m_av = 0; m_steal = 0; m_vrst = '0;
    endtask

    task automatic model_event(bit on, int note, logic [31:0] incr);
        int v;
        m_av = 0; m_steal = 0; m_vrst = '0;
        if (on) begin
            v = -1;
            for (int i = 0; i < NV; i++) if (v < 0 && m_act[i] && m_note[i] == note) v = i;
            for (int i = 0; i < NV; i++) if (v < 0 && !m_act[i]) v = i;
            if (v < 0) begin
                m_steal = 1;
                v = 0;
                for (int i = 1; i < NV; i++) if (m_age[i] > m_age[v]) v = i;
            end
            for (int i = 0; i < NV; i++)
                if (i != v && m_act[i] && m_age[i] < 255) m_age[i]++;
            m_act[v] = 1; m_note[v] = note; m_incr[v] = incr; m_age[v] = 0;
            m_av = 1; m_vrst[v] = 1'b1; m_last = v;
        end else begin
            for (int i = 0; i < NV; i++) if (m_act[i] && m_note[i] == note) m_act[i] = 0;
        end
    endtask

    task automatic check_state(string tag);
        logic [NV-1:0]    ea;
        logic [NV*NW-1:0] en;
        logic [NV*IW-1:0] ei;
        for (int i = 0; i < NV; i++) begin
            ea[i] = m_act[i];
            en[i*NW +: NW] = NW'(m_note[i]);
            ei[i*IW +: IW] = m_incr[i];
        end
        chk({tag, "_active"}, 256'(v_active), 256'(ea));
        chk({tag, "_note"}, 256'(v_note), 256'(en));
        chk({tag, "_incr"}, 256'(v_incr), 256'(ei));
        chk({tag, "_voice"}, 256'(alloc_voice), 256'(m_last));
    endtask

    task automatic check_pulses(string tag, bit av, bit st, logic [NV-1:0] vr);
        chk({tag, "_alloc_valid"}, 256'(alloc_valid), 256'(av));
        chk({tag, "_steal"}, 256'(steal), 256'(st));
        chk({tag, "_vrst"}, 256'(v_rst), 256'(vr));
    endtask

    // Called at a negedge; returns at the negedge where the DUT is idle again.
    task automatic send(string tag, bit on, int note, logic [31:0] incr);
        int w = 0;
        while (!evt_ready && w < 20) begin @(negedge clk); w++; end
        chk({tag, "_ready"}, 256'(evt_ready), 256'(1));
        evt_valid = 1; evt_on = on; evt_note = NW'(note); evt_incr = incr;
        @(posedge clk); #1;
        evt_valid = 0; evt_on = 0; evt_note = '0; evt_incr = '0;
        model_event(on, note, incr);
        @(negedge clk);
        check_pulses({tag, "_search"}, 0, 0, '0);
        @(negedge clk);
        check_state(tag);
        check_pulses(tag, m_av, m_steal, m_vrst);
        @(negedge clk);
        check_pulses({tag, "_idle"}, 0, 0, '0);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        rst = 1;
        #1 chk({tag, "_ready_in_rst"}, 256'(evt_ready), 256'(0));
        @(posedge clk); #1;
        model_reset();
        check_state({tag, "_rst"});
        check_pulses({tag, "_rst"}, 0, 0, '0);
        @(negedge clk);
        rst = 0;
        #1 chk({tag, "_ready_after_rst"}, 256'(evt_ready), 256'(1));
        @(negedge clk);
    endtask

    initial begin
        rst = 1; evt_valid = 0; evt_on = 0; evt_note = '0; evt_incr = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // 1: first note-on lands on voice 0
        do_reset("t1");
        send("t1_on60", 1, 60, 32'h0100_0000);
        chk("t1_active_const", 256'(v_active), 256'(8'h01));

        // 2: released voice is reused first
        do_reset("t2");
        send("t2_on60", 1, 60, 32'h11);
        send("t2_on62", 1, 62, 32'h22);
        send("t2_on64", 1, 64, 32'h33);
        send("t2_off62", 0, 62, 32'h0);
        chk("t2_active_const", 256'(v_active), 256'(8'b0000_0101));
        send("t2_on67", 1, 67, 32'h44);
        chk("t2_voice_const", 256'(alloc_voice), 256'(1));

        // 3: full bank, oldest voices stolen in order
        do_reset("t3");
        for (int n = 60; n < 68; n++) send("t3_fill", 1, n, 32'(n * 16));
        send("t3_on70", 1, 70, 32'h700);
        chk("t3_note0_const", 256'(v_note[NW-1:0]), 256'(70));
        send("t3_on71", 1, 71, 32'h710);
        chk("t3_voice_const", 256'(alloc_voice), 256'(1));

        // 4: retrigger same note, new increment, no steal
        do_reset("t4");
        send("t4_onA", 1, 60, 32'hAAAA_0000);
        send("t4_onB", 1, 60, 32'hBBBB_0000);
        chk("t4_incr_const", 256'(v_incr[IW-1:0]), 256'(32'hBBBB_0000));

        // 5: note-off for a note never played changes nothing
        send("t5_off99", 0, 99, 32'h0);

        // 6: reset during SEARCH drops the event
        @(negedge clk);
        evt_valid = 1; evt_on = 1; evt_note = 7'd50; evt_incr = 32'h5;
        @(posedge clk); #1;
        evt_valid = 0;
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        model_reset();
        check_state("t6_rst");
        check_pulses("t6_rst", 0, 0, '0);
        @(negedge clk);
        rst = 0;
        #1 chk("t6_ready_after_rst", 256'(evt_ready), 256'(1));
        send("t6_after", 1, 52, 32'h0);

        // Random traffic over a narrow note range so retriggers, releases
        // and steals all occur; increment 0 appears as a legal value too.
        for (int k = 0; k < 200; k++) begin
            bit on = ($urandom_range(0, 4) < 3);
            int note = 40 + $urandom_range(0, 11);
            logic [31:0] incr = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            send("rnd", on, note, incr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
